// File: rtl/q_pattern_source.sv
// q_pattern_source
//   Programmable 4-bit sequence source for the all-ones capture stage.
//   The sequence steps once every DIV enabled cycles (run=1) using one of
//   four step functions (up, down, 15-state LFSR, hold), and can be loaded
//   directly at any time. Registered one-cycle pulses mark every write of Q
//   (step) and every write of 4'b1111 (term). A saturating counter tallies
//   term pulses for debug readout.
//
// Parameters
//   DIV        enabled clock cycles per sequence step, 1..256
//   WRAP_W     width of wrap_count
//
// Ports
//   clk        system clock, rising edge
//   reset_n    asynchronous active-low reset
//   run        prescaler enable; 0 freezes prescaler and Q (load still works)
//   mode       step function: 00 up, 01 down, 10 LFSR, 11 hold
//   load       synchronous load of load_val into Q (beats a step)
//   load_val   value written by load
//   clr_wrap   synchronous clear of wrap_count (beats an increment)
//   Q          registered sequence value
//   step       one-cycle pulse coinciding with a freshly written Q
//   term       one-cycle pulse coinciding with a freshly written 4'b1111
//   wrap_count saturating count of term pulses
module q_pattern_source #(
  parameter int unsigned DIV    = 4,
  parameter int unsigned WRAP_W = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              run,
  input  logic [1:0]        mode,
  input  logic              load,
  input  logic [3:0]        load_val,
  input  logic              clr_wrap,
  output logic [3:0]        Q,
  output logic              step,
  output logic              term,
  output logic [WRAP_W-1:0] wrap_count
);

  localparam int unsigned PRE_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(DIV - 1);

  typedef enum logic [1:0] {
    MODE_UP   = 2'b00,
    MODE_DOWN = 2'b01,
    MODE_LFSR = 2'b10,
    MODE_HOLD = 2'b11
  } mode_e;

  mode_e mode_s;

  logic [PRE_W-1:0]  pre_cnt_q, pre_cnt_d;
  logic [3:0]        q_q, q_d;
  logic              step_q, step_d;
  logic              term_q, term_d;
  logic [WRAP_W-1:0] wrap_count_q, wrap_count_d;

  logic              adv;
  logic              write;
  logic [3:0]        next_val;

  assign mode_s = mode_e'(mode);

  always_comb begin
    adv = run && (pre_cnt_q == PRE_LAST);

    next_val = q_q;
    unique case (mode_s)
      MODE_UP:   next_val = q_q + 4'd1;
      MODE_DOWN: next_val = q_q - 4'd1;
      // x^4+x^3+1 maximal-length shift; the all-zero state would lock up,
      // so it is steered into the sequence at 0001.
      MODE_LFSR: next_val = (q_q == 4'd0) ? 4'd1 : {q_q[2:0], q_q[3] ^ q_q[2]};
      MODE_HOLD: next_val = q_q;
      default:   next_val = q_q;
    endcase

    // Hold mode still lets the prescaler wrap but does not count as a write.
    write = load || (adv && (mode_s != MODE_HOLD));

    if (load) begin
      q_d = load_val;
    end else if (write) begin
      q_d = next_val;
    end else begin
      q_d = q_q;
    end

    if (load || adv) begin
      pre_cnt_d = '0;
    end else if (run) begin
      pre_cnt_d = pre_cnt_q + PRE_W'(1);
    end else begin
      pre_cnt_d = pre_cnt_q;
    end

    step_d = write;
    term_d = write && (q_d == 4'hF);

    if (clr_wrap) begin
      wrap_count_d = '0;
    end else if (term_d && (wrap_count_q != '1)) begin
      wrap_count_d = wrap_count_q + WRAP_W'(1);
    end else begin
      wrap_count_d = wrap_count_q;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pre_cnt_q    <= '0;
      q_q          <= '0;
      step_q       <= 1'b0;
      term_q       <= 1'b0;
      wrap_count_q <= '0;
    end else begin
      pre_cnt_q    <= pre_cnt_d;
      q_q          <= q_d;
      step_q       <= step_d;
      term_q       <= term_d;
      wrap_count_q <= wrap_count_d;
    end
  end

  assign Q          = q_q;
  assign step       = step_q;
  assign term       = term_q;
  assign wrap_count = wrap_count_q;

endmodule

// File: tb/tb_q_pattern_source.sv
// Testbench for q_pattern_source: DIV=4 instance with WRAP_W=8, plus a
// WRAP_W=2 instance on the same stimulus for wrap_count saturation.
module tb_q_pattern_source;

  typedef struct packed {
    logic [3:0] q;
    logic       st;
    logic       tm;
    logic [7:0] wc;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       run = 1'b0;
  logic [1:0] mode = 2'b00;
  logic       load = 1'b0;
  logic [3:0] load_val = 4'd0;
  logic       clr_wrap = 1'b0;

  logic [3:0] Q, Q2;
  logic       step, step2, term, term2;
  logic [7:0] wrap_count;
  logic [1:0] wrap2;

  int n_cmp = 0;
  int n_err = 0;

  exp_t       exp_q[$];
  logic [1:0] w2_q[$];
  exp_t       e;
  logic [1:0] w2;

  q_pattern_source #(.DIV(4), .WRAP_W(8)) dut (
    .clk(clk), .reset_n(reset_n), .run(run), .mode(mode), .load(load),
    .load_val(load_val), .clr_wrap(clr_wrap), .Q(Q), .step(step),
    .term(term), .wrap_count(wrap_count)
  );

  q_pattern_source #(.DIV(4), .WRAP_W(2)) dut_sat (
    .clk(clk), .reset_n(reset_n), .run(run), .mode(mode), .load(load),
    .load_val(load_val), .clr_wrap(clr_wrap), .Q(Q2), .step(step2),
    .term(term2), .wrap_count(wrap2)
  );

  always #5 clk = ~clk;

  // Advance n rising edges, then settle 1 time unit past the last edge.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    run = 1'b0; mode = 2'b00; load = 1'b0; load_val = 4'd0; clr_wrap = 1'b0;
    reset_n = 1'b0;
    tick(1);
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    load = 1'b1; load_val = 4'd7;
    tick(1);
    load = 1'b0; run = 1'b1; mode = 2'b00;
    tick(2);
    exp_q.push_back('{4'd7, 1'b0, 1'b0, 8'd0});
    e = exp_q.pop_front(); n_cmp++;
    if ({Q, step, term, wrap_count} !== e) begin
      n_err++; $display("FAIL reset_premid: got %h/%b/%b/%0d want %h/%b/%b/%0d", Q, step, term, wrap_count, e.q, e.st, e.tm, e.wc);
    end
    reset_n = 1'b0;
    exp_q.push_back('{4'd0, 1'b0, 1'b0, 8'd0});
    #1;
    e = exp_q.pop_front(); n_cmp++;
    if ({Q, step, term, wrap_count} !== e) begin
      n_err++; $display("FAIL reset_async: got %h/%b/%b/%0d want %h/%b/%b/%0d", Q, step, term, wrap_count, e.q, e.st, e.tm, e.wc);
    end
    tick(1);
    reset_n = 1'b1;
    exp_q.push_back('{4'd0, 1'b0, 1'b0, 8'd0});
    exp_q.push_back('{4'd1, 1'b1, 1'b0, 8'd0});
    tick(3);
    e = exp_q.pop_front(); n_cmp++;
    if ({Q, step, term, wrap_count} !== e) begin
      n_err++; $display("FAIL reset_edge3: got %h/%b/%b/%0d want %h/%b/%b/%0d", Q, step, term, wrap_count, e.q, e.st, e.tm, e.wc);
    end
    tick(1);
    e = exp_q.pop_front(); n_cmp++;
    if ({Q, step, term, wrap_count} !== e) begin
      n_err++; $display("FAIL reset_first_step: got %h/%b/%b/%0d want %h/%b/%b/%0d", Q, step, term, wrap_count, e.q, e.st, e.tm, e.wc);
    end
  endtask

  task automatic test_up_count();
    do_reset();
    run = 1'b1; mode = 2'b00;
    exp_q.push_back('{4'd14, 1'b0, 1'b0, 8'd0});
    exp_q.push_back('{4'd15, 1'b1, 1'b1, 8'd1});
    exp_q.push_back('{4'd15, 1'b0, 1'b0, 8'd1});
    exp_q.push_back('{4'd0,  1'b1, 1'b0, 8'd1});
    tick(59);
    e = exp_q.pop_front(); n_cmp++;
    if ({Q, step, term, wrap_count} !== e) begin
      n_err++; $display("FAIL up_c59: got %h/%b/%b/%0d want %h/%b/%b/%0d", Q, step, term, wrap_count, e.q, e.st, e.tm, e.wc);
    end
    tick(1);
    e = exp_q.pop_front(); n_cmp++;
    if ({Q, step, term, wrap_count} !== e) begin
      n_err++; $display("FAIL up_term: got %h/%b/%b/%0d want %h/%b/%b/%0d", Q, step, term, wrap_count, e.q, e.st, e.tm, e.wc);
    end
    tick(1);
    e = exp_q.pop_front(); n_cmp++;
    if ({Q, step, term, wrap_count} !== e) begin
      n_err++; $display("FAIL up_term_width: got %h/%b/%b/%0d want %h/%b/%b/%0d", Q, step, term, wrap_count, e.q, e.st, e.tm, e.wc);
    end
    tick(3);
    e = exp_q.pop_front(); n_cmp++;
    if ({Q, step, term, wrap_count} !== e) begin
      n_err++; $display("FAIL up_wrap0: got %h/%b/%b/%0d want %h/%b/%b/%0d", Q, step, term, wrap_count, e.q, e.st, e.tm, e.wc);
    end
  endtask

  task automatic test_down_lfsr();
    logic [3:0] seq [15];
    int n_term;
    seq = '{4'h2, 4'h4, 4'h9, 4'h3, 4'h6, 4'hD, 4'hA, 4'h5,
            4'hB, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8, 4'h1};
    do_reset();
    run = 1'b1; mode = 2'b01;
    exp_q.push_back('{4'd15, 1'b1, 1'b1, 8'd1});
    tick(4);
    e = exp_q.pop_front(); n_cmp++;
    if ({Q, step, term, wrap_count} !== e) begin
      n_err++; $display("FAIL down_wrap: got %h/%b/%b/%0d want %h/%b/%b/%0d", Q, step, term, wrap_count, e.q, e.st, e.tm, e.wc);
    end
    // Seed the LFSR with 0001 and walk one full period.
    run = 1'b0; mode = 2'b10; load = 1'b1; load_val = 4'd1;
    tick(1);
    load = 1'b0; run = 1'b1;
    for (int i = 0; i < 15; i++)
      exp_q.push_back('{seq[i], 1'b1, (seq[i] == 4'hF), (i >= 10) ? 8'd2 : 8'd1});
    n_term = 0;
    for (int i = 0; i < 15; i++) begin
      for (int k = 0; k < 4; k++) begin
        tick(1);
        if (term === 1'b1) n_term++;
      end
      e = exp_q.pop_front(); n_cmp++;
      if ({Q, step, term, wrap_count} !== e) begin
        n_err++; $display("FAIL lfsr_step%0d: got %h/%b/%b/%0d want %h/%b/%b/%0d", i, Q, step, term, wrap_count, e.q, e.st, e.tm, e.wc);
      end
    end
    n_cmp++;
    if (n_term !== 1) begin
      n_err++; $display("FAIL lfsr_terms: got %0d want 1", n_term);
    end
    run = 1'b0; load = 1'b1; load_val = 4'd0;
    exp_q.push_back('{4'd0, 1'b1, 1'b0, 8'd2});
    exp_q.push_back('{4'd1, 1'b1, 1'b0, 8'd2});
    tick(1);
    load = 1'b0; run = 1'b1;
    e = exp_q.pop_front(); n_cmp++;
    if ({Q, step, term, wrap_count} !== e) begin
      n_err++; $display("FAIL lfsr_seed0: got %h/%b/%b/%0d want %h/%b/%b/%0d", Q, step, term, wrap_count, e.q, e.st, e.tm, e.wc);
    end
    tick(4);
    e = exp_q.pop_front(); n_cmp++;
    if ({Q, step, term, wrap_count} !== e) begin
      n_err++; $display("FAIL lfsr_escape: got %h/%b/%b/%0d want %h/%b/%b/%0d", Q, step, term, wrap_count, e.q, e.st, e.tm, e.wc);
    end
  endtask

  task automatic test_load();
    do_reset();
    load = 1'b1; load_val = 4'hF;
    exp_q.push_back('{4'hF, 1'b1, 1'b1, 8'd1});
    exp_q.push_back('{4'hF, 1'b1, 1'b1, 8'd2});
    exp_q.push_back('{4'hF, 1'b0, 1'b0, 8'd2});
    tick(1);
    e = exp_q.pop_front(); n_cmp++;
    if ({Q, step, term, wrap_count} !== e) begin
      n_err++; $display("FAIL load_ff: got %h/%b/%b/%0d want %h/%b/%b/%0d", Q, step, term, wrap_count, e.q, e.st, e.tm, e.wc);
    end
    tick(1);
    e = exp_q.pop_front(); n_cmp++;
    if ({Q, step, term, wrap_count} !== e) begin
      n_err++; $display("FAIL load_ff_again: got %h/%b/%b/%0d want %h/%b/%b/%0d", Q, step, term, wrap_count, e.q, e.st, e.tm, e.wc);
    end
    load = 1'b0;
    tick(1);
    e = exp_q.pop_front(); n_cmp++;
    if ({Q, step, term, wrap_count} !== e) begin
      n_err++; $display("FAIL load_release: got %h/%b/%b/%0d want %h/%b/%b/%0d", Q, step, term, wrap_count, e.q, e.st, e.tm, e.wc);
    end
    // Load on the same edge as adv (pre_cnt reaches 3 after three edges).
    run = 1'b1; mode = 2'b00;
    tick(3);
    load = 1'b1; load_val = 4'd5;
    exp_q.push_back('{4'd5, 1'b1, 1'b0, 8'd2});
    exp_q.push_back('{4'd5, 1'b0, 1'b0, 8'd2});
    exp_q.push_back('{4'd6, 1'b1, 1'b0, 8'd2});
    tick(1);
    load = 1'b0;
    e = exp_q.pop_front(); n_cmp++;
    if ({Q, step, term, wrap_count} !== e) begin
      n_err++; $display("FAIL load_vs_adv: got %h/%b/%b/%0d want %h/%b/%b/%0d", Q, step, term, wrap_count, e.q, e.st, e.tm, e.wc);
    end
    tick(3);
    e = exp_q.pop_front(); n_cmp++;
    if ({Q, step, term, wrap_count} !== e) begin
      n_err++; $display("FAIL load_adv_pre3: got %h/%b/%b/%0d want %h/%b/%b/%0d", Q, step, term, wrap_count, e.q, e.st, e.tm, e.wc);
    end
    tick(1);
    e = exp_q.pop_front(); n_cmp++;
    if ({Q, step, term, wrap_count} !== e) begin
      n_err++; $display("FAIL load_adv_next: got %h/%b/%b/%0d want %h/%b/%b/%0d", Q, step, term, wrap_count, e.q, e.st, e.tm, e.wc);
    end
    // Load mid-count restarts the prescaler from 0.
    tick(2);
    load = 1'b1; load_val = 4'd9;
    exp_q.push_back('{4'd9,  1'b1, 1'b0, 8'd2});
    exp_q.push_back('{4'd9,  1'b0, 1'b0, 8'd2});
    exp_q.push_back('{4'd10, 1'b1, 1'b0, 8'd2});
    tick(1);
    load = 1'b0;
    e = exp_q.pop_front(); n_cmp++;
    if ({Q, step, term, wrap_count} !== e) begin
      n_err++; $display("FAIL load_mid: got %h/%b/%b/%0d want %h/%b/%b/%0d", Q, step, term, wrap_count, e.q, e.st, e.tm, e.wc);
    end
    tick(3);
    e = exp_q.pop_front(); n_cmp++;
    if ({Q, step, term, wrap_count} !== e) begin
      n_err++; $display("FAIL load_mid_pre3: got %h/%b/%b/%0d want %h/%b/%b/%0d", Q, step, term, wrap_count, e.q, e.st, e.tm, e.wc);
    end
    tick(1);
    e = exp_q.pop_front(); n_cmp++;
    if ({Q, step, term, wrap_count} !== e) begin
      n_err++; $display("FAIL load_mid_next: got %h/%b/%b/%0d want %h/%b/%b/%0d", Q, step, term, wrap_count, e.q, e.st, e.tm, e.wc);
    end
  endtask

  task automatic test_hold_freeze();
    int pulses;
    do_reset();
    load = 1'b1; load_val = 4'hF;
    tick(1);
    load = 1'b0; run = 1'b1; mode = 2'b11;
    pulses = 0;
    for (int i = 0; i < 80; i++) begin
      tick(1);
      if (step === 1'b1 || term === 1'b1) pulses++;
    end
    n_cmp++;
    if (pulses !== 0) begin
      n_err++; $display("FAIL hold_pulses: got %0d want 0", pulses);
    end
    exp_q.push_back('{4'hF, 1'b0, 1'b0, 8'd1});
    exp_q.push_back('{4'hF, 1'b0, 1'b0, 8'd1});
    exp_q.push_back('{4'hF, 1'b0, 1'b0, 8'd1});
    exp_q.push_back('{4'h0, 1'b1, 1'b0, 8'd1});
    e = exp_q.pop_front(); n_cmp++;
    if ({Q, step, term, wrap_count} !== e) begin
      n_err++; $display("FAIL hold_state: got %h/%b/%b/%0d want %h/%b/%b/%0d", Q, step, term, wrap_count, e.q, e.st, e.tm, e.wc);
    end
    // Freeze with pre_cnt at 2; resume needs exactly two more edges.
    mode = 2'b00;
    tick(2);
    run = 1'b0;
    tick(10);
    e = exp_q.pop_front(); n_cmp++;
    if ({Q, step, term, wrap_count} !== e) begin
      n_err++; $display("FAIL freeze: got %h/%b/%b/%0d want %h/%b/%b/%0d", Q, step, term, wrap_count, e.q, e.st, e.tm, e.wc);
    end
    run = 1'b1;
    tick(1);
    e = exp_q.pop_front(); n_cmp++;
    if ({Q, step, term, wrap_count} !== e) begin
      n_err++; $display("FAIL resume_pre3: got %h/%b/%b/%0d want %h/%b/%b/%0d", Q, step, term, wrap_count, e.q, e.st, e.tm, e.wc);
    end
    tick(1);
    e = exp_q.pop_front(); n_cmp++;
    if ({Q, step, term, wrap_count} !== e) begin
      n_err++; $display("FAIL resume_step: got %h/%b/%b/%0d want %h/%b/%b/%0d", Q, step, term, wrap_count, e.q, e.st, e.tm, e.wc);
    end
  endtask

  task automatic test_saturate_clear();
    logic [1:0] sat_tab [5];
    sat_tab = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    do_reset();
    load = 1'b1; load_val = 4'hF;
    for (int i = 0; i < 5; i++) w2_q.push_back(sat_tab[i]);
    for (int i = 0; i < 5; i++) begin
      tick(1);
      w2 = w2_q.pop_front(); n_cmp++;
      if (wrap2 !== w2) begin
        n_err++; $display("FAIL sat_term%0d: got %0d want %0d", i, wrap2, w2);
      end
    end
    exp_q.push_back('{4'hF, 1'b1, 1'b1, 8'd0});
    w2_q.push_back(2'd0);
    clr_wrap = 1'b1;
    tick(1);
    clr_wrap = 1'b0; load = 1'b0;
    e = exp_q.pop_front(); n_cmp++;
    if ({Q, step, term, wrap_count} !== e) begin
      n_err++; $display("FAIL clr_vs_term: got %h/%b/%b/%0d want %h/%b/%b/%0d", Q, step, term, wrap_count, e.q, e.st, e.tm, e.wc);
    end
    w2 = w2_q.pop_front(); n_cmp++;
    if (wrap2 !== w2) begin
      n_err++; $display("FAIL clr_vs_term_sat: got %0d want %0d", wrap2, w2);
    end
  endtask

  initial begin
    test_reset();
    test_up_count();
    test_down_lfsr();
    test_load();
    test_hold_freeze();
    test_saturate_clear();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/q_pattern_source.md
# q_pattern_source

Sequence source that drives the 4-bit `Q` bus of the all-ones capture stage. It produces a programmable 4-bit sequence: up count, down count, 15-state LFSR, or hold. The sequence advances at a prescaled rate and can be loaded directly. It emits cycle-aligned pulses when `Q` advances and when `Q` reaches 4'b1111, which the capture stage keys on. It also keeps a saturating count of all-ones events for debug readout.

## Interface

Parameters:
- `DIV`, default 4: enabled clock cycles per sequence step. Legal range 1..256.
- `WRAP_W`, default 8: width of `wrap_count`.

Ports:
- `clk`  in  1  single system clock; all state updates on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `run`  in  1  prescaler enable. 1 = prescaler runs; 0 = prescaler and `Q` frozen. Load still works when `run`=0.
- `mode`  in  2  step function: 00 up, 01 down, 10 LFSR, 11 hold. Sampled on each step.
- `load`  in  1  synchronous load of `load_val` into `Q`.
- `load_val`  in  4  value loaded into `Q`.
- `clr_wrap`  in  1  synchronous clear of `wrap_count`.
- `Q`  out  4  registered sequence value, fed to the capture stage.
- `step`  out  1  registered; high for the one cycle in which `Q` holds a value just written by a step or load.
- `term`  out  1  registered; high for the first cycle `Q` equals 4'b1111 after a step or load that wrote 1111.
- `wrap_count`  out  WRAP_W  number of `term` pulses, saturating.

## Operation

- **Prescaler** `pre_cnt`:
  - Counts 0..DIV-1 while `run`=1 and holds while `run`=0.
  - `adv` = `run` && `pre_cnt`==DIV-1. On `adv`, `pre_cnt` wraps to 0.
  - With DIV=1, `adv` is high on every cycle with `run`=1.
- **Next-value rules**, evaluated on `adv`:
  - up: Q+1 mod 16. 1111 wraps to 0000.
  - down: Q-1 mod 16. 0000 wraps to 1111.
  - LFSR: {Q[2:0], Q[3]^Q[2]}. Period 15 over the nonzero states. If Q=0000, the next value is 0001 (lock-up escape).
  - hold: Q unchanged. `step` and `term` are not asserted.
- **Priority**: `load` > `adv`.
  - `load` writes `load_val`, clears `pre_cnt` to 0, and asserts `step`.
  - `load` wins regardless of `run` or `mode`.
- **Pulse registers**:
  - `term` <= (write occurred) && (written value == 1111).
  - A value that stays at 1111 (hold mode, `run`=0) produces no further `term`.
  - Loading 1111 while `Q` is already 1111 produces a new `term`.
- **`wrap_count`**:
  - Increments on the same edge that sets `term`, and saturates at all-ones.
  - `clr_wrap` has priority; clear and increment in the same cycle give 0.
- **Reset values**: `Q`=0000, `pre_cnt`=0, `step`=0, `term`=0, `wrap_count`=0.
- **Reset mid-operation**: all state returns to the reset values immediately and asynchronously. First step after release follows the normal prescaler timing.
- A `mode` change between steps takes effect at the next `adv`. It does not reset `pre_cnt`.

## Timing

- **Latency**:
  - `load` sampled at edge n: `Q`=`load_val`, `step`=1 (and `term` if 1111) during cycle n..n+1.
  - `run` asserted before edge 0 with `pre_cnt`=0: first step lands at edge DIV-1. Subsequent steps follow every DIV enabled edges.
- `step` and `term` are exactly one cycle wide and coincide with the new `Q`. There are no combinational paths from inputs to outputs.
- `run` deasserted mid-count: `pre_cnt` holds. After reassertion, counting resumes from the held value.
- `term` falls on the edge where `Q` leaves 1111, or one cycle later in hold or `run`=0. The capture stage must therefore see 1111 for at least one full cycle.

## Test plan

1. **Reset defaults**: assert `reset_n`=0 mid-count with `Q`=0111 -> `Q`=0000, `step`=`term`=0, `wrap_count`=0 before the next edge. After release with `run`=1, DIV=4: first step to 0001 at the 4th edge.
2. **Up count**: DIV=4, mode=00, `run`=1 from 0000 -> `Q`=1111 after 60 cycles. `term` high for exactly 1 cycle, `wrap_count`=1. `Q`=0000 four cycles later.
3. **Down count and LFSR**:
   - Down: from 0000 -> first step gives 1111 with `term`.
   - LFSR, seed 0001: exactly 15 steps before 0001 repeats, exactly one `term` per period. Seed 0000 -> next value 0001.
4. **Load priority**:
   - `load`=1, `load_val`=1111, `run`=0 -> `Q`=1111, `step`=`term`=1 for one cycle, `wrap_count`+1.
   - Repeat the load -> second `term`.
   - `load` coincident with `adv` -> `load_val` wins and `pre_cnt`=0.
5. **Hold and freeze**: mode=11 at `Q`=1111 over 20 steps -> no `step`/`term`, `wrap_count` unchanged. `run`=0 for 10 cycles mid-count -> `Q` and `pre_cnt` frozen.
6. **Saturation and clear**: WRAP_W=2, 5 `term` events -> `wrap_count`=3. `clr_wrap` coincident with `term` -> 0.
